// File: rtl/regfile_initiator_pkg.sv
// Shared encodings for the register-file initiator: command opcodes and FSM states.
package regfile_initiator_pkg;

    // Command opcodes carried on cmd_op.
    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_COPY  = 2'b11
    } opT;

    // Initiator FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } stateT;

endpackage : regfile_initiator_pkg

// File: rtl/regfile_initiator.sv
// Command-driven master for the 8x32 register file access port.
// Turns WRITE/READ/COPY commands into single-cycle rf_we/rf_re pulses and
// returns one response per command.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | cmd_ready=1, waiting for a command
// RD    | rf_re=1 for one cycle, rf_rData captured at the closing edge
// WR    | rf_we=1 for one cycle, register file writes at the closing edge
// RESP  | rsp_valid=1, rsp_data held until rsp_ready
module regfile_initiator
    import regfile_initiator_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rf_wAddr,
    output logic [DATA_W-1:0] rf_wData,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_rAddr,
    output logic              rf_re,
    input  logic [DATA_W-1:0] rf_rData,
    output logic [CNT_W-1:0]  ops_done
);

    stateT             state;
    stateT             nextState;
    opT                opReg;
    opT                cmdOp;
    logic [DATA_W-1:0] dataReg;
    logic [ADDR_W-1:0] wAddrReg;
    logic [ADDR_W-1:0] rAddrReg;
    logic [CNT_W-1:0]  opsCnt;
    logic              cmdAccept;
    logic              rspFire;

    assign cmdOp     = opT'(cmd_op);
    assign cmdAccept = cmd_valid && (state == IDLE);
    assign rspFire   = (state == RESP) && rsp_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and Moore outputs; enables are gated by reset so a write
    // caught mid-flight by reset never reaches the register file.
    always_comb begin
        nextState = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        rf_we     = 1'b0;
        rf_re     = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    case (cmdOp)
                        OP_WRITE: nextState = WR;
                        OP_READ:  nextState = RD;
                        OP_COPY:  nextState = RD;
                        default:  nextState = IDLE;
                    endcase
                end
            end
            RD: begin
                rf_re     = ~reset;
                nextState = (opReg == OP_COPY) ? WR : RESP;
            end
            WR: begin
                rf_we     = ~reset;
                nextState = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Command capture and data register. Addresses are loaded at accept so
    // they are already stable during the RD/WR cycle; the data register holds
    // WRITE data, or the value read in RD for READ/COPY.
    always_ff @(posedge clk) begin
        if (reset) begin
            opReg    <= OP_NOP;
            wAddrReg <= '0;
            rAddrReg <= '0;
            dataReg  <= '0;
        end else begin
            if (cmdAccept && (cmdOp != OP_NOP)) begin
                opReg    <= cmdOp;
                wAddrReg <= cmd_addr;
                rAddrReg <= (cmdOp == OP_READ) ? cmd_addr : cmd_src;
                dataReg  <= cmd_data;
            end
            if (state == RD) begin
                dataReg <= rf_rData;
            end
        end
    end

    // Completed-response counter; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            opsCnt <= '0;
        end else if (rspFire) begin
            opsCnt <= opsCnt + 1'b1;
        end
    end

    assign rf_wAddr = wAddrReg;
    assign rf_wData = dataReg;
    assign rf_rAddr = rAddrReg;
    assign rsp_data = dataReg;
    assign ops_done = opsCnt;

endmodule : regfile_initiator

// File: tb/tb_regfile_initiator.sv
// Scoreboard bench for regfile_initiator with a behavioural 8x32 register file.
module tb_regfile_initiator;

    localparam int DW = 32;
    localparam int AW = 3;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [AW-1:0] cmd_src;
    logic [DW-1:0] cmd_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] rf_wAddr;
    logic [DW-1:0] rf_wData;
    logic          rf_we;
    logic [AW-1:0] rf_rAddr;
    logic          rf_re;
    logic [DW-1:0] rf_rData;
    logic [CW-1:0] ops_done;

    int nTests = 0;
    int nFail  = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    regfile_initiator #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_src(cmd_src), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rf_wAddr(rf_wAddr), .rf_wData(rf_wData), .rf_we(rf_we),
        .rf_rAddr(rf_rAddr), .rf_re(rf_re), .rf_rData(rf_rData),
        .ops_done(ops_done)
    );

    // Behavioural register file: synchronous write, combinational read.
    logic [DW-1:0] rfMem [8];
    logic          rfInit;
    always @(posedge clk) begin
        if (rfInit) begin
            for (int i = 0; i < 8; i++) rfMem[i] <= 32'h1000_0000 + i;
        end else if (rf_we) begin
            rfMem[rf_wAddr] <= rf_wData;
        end
    end
    assign rf_rData = rf_re ? rfMem[rf_rAddr] : '0;

    // Expected traffic, pushed by stimulus and popped by the monitor.
    logic [AW+DW-1:0] expWrQ[$];
    logic [AW-1:0]    expRdQ[$];
    logic [DW-1:0]    expRspQ[$];
    int               expLatQ[$];

    logic [DW-1:0] shadow [8];
    logic [CW-1:0] expOps;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every rf strobe, every response handshake and the
    // accept-to-response latency against the queued expectations.
    int acceptCyc = 0;
    bit pend = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            pend = 1'b0;
        end else begin
            if (cmd_valid && cmd_ready && cmd_op != 2'b00) begin
                acceptCyc = cyc;
                pend = 1'b1;
            end
            if (rsp_valid && pend) begin
                pend = 1'b0;
                if (expLatQ.size() == 0) check("latency_unexpected", 64'(cyc - acceptCyc), 64'hFFFF);
                else check("latency", 64'(cyc - acceptCyc), 64'(expLatQ.pop_front()));
            end
            if (rf_we) begin
                if (expWrQ.size() == 0) check("unexpected_write", {61'd0, rf_wAddr}, 64'hFFFF);
                else begin
                    logic [AW+DW-1:0] w;
                    w = expWrQ.pop_front();
                    check("wr_addr", 64'(rf_wAddr), 64'(w[AW+DW-1:DW]));
                    check("wr_data", 64'(rf_wData), 64'(w[DW-1:0]));
                end
            end
            if (rf_re) begin
                if (expRdQ.size() == 0) check("unexpected_read", {61'd0, rf_rAddr}, 64'hFFFF);
                else check("rd_addr", 64'(rf_rAddr), 64'(expRdQ.pop_front()));
            end
            if (rsp_valid && rsp_ready) begin
                if (expRspQ.size() == 0) check("unexpected_rsp", 64'(rsp_data), 64'hFFFF_FFFF_FFFF);
                else check("rsp_data", 64'(rsp_data), 64'(expRspQ.pop_front()));
            end
        end
    end

    task automatic sendCmd(input logic [1:0] op, input logic [AW-1:0] addr, input logic [AW-1:0] src,
                           input logic [DW-1:0] data, input bit expRsp, input logic [DW-1:0] rspVal,
                           input int lat);
        int n = 0;
        @(posedge clk); #1;
        while (!cmd_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!cmd_ready) check("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_src   = src;
        cmd_data  = data;
        if (expRsp) begin
            expRspQ.push_back(rspVal);
            expLatQ.push_back(lat);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
    endtask

    task automatic waitIdle();
        int n = 0;
        while (!cmd_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!cmd_ready) check("idle_timeout", 64'(cmd_ready), 64'd1);
    endtask

    task automatic doWrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
        expWrQ.push_back({a, d});
        shadow[a] = d;
        sendCmd(2'b01, a, '0, d, 1'b1, d, 2);
        waitIdle();
        expOps++;
        check("ops_done_write", 64'(ops_done), 64'(expOps));
    endtask

    task automatic doRead(input logic [AW-1:0] a);
        expRdQ.push_back(a);
        sendCmd(2'b10, a, '0, 32'hFFFF_0000, 1'b1, shadow[a], 2);
        waitIdle();
        expOps++;
        check("ops_done_read", 64'(ops_done), 64'(expOps));
    endtask

    task automatic doCopy(input logic [AW-1:0] s, input logic [AW-1:0] d);
        logic [DW-1:0] v;
        v = shadow[s];
        expRdQ.push_back(s);
        expWrQ.push_back({d, v});
        shadow[d] = v;
        sendCmd(2'b11, d, s, 32'h0BAD_0BAD, 1'b1, v, 3);
        waitIdle();
        expOps++;
        check("ops_done_copy", 64'(ops_done), 64'(expOps));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; rfInit = 1'b1;
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_src = '0; cmd_data = '0;
        rsp_ready = 1'b1;
        expOps = '0;
        for (int i = 0; i < 8; i++) shadow[i] = 32'h1000_0000 + i;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0; rfInit = 1'b0;

        @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rf_we",     64'(rf_we),     64'd0);
        check("rst_rf_re",     64'(rf_re),     64'd0);
        check("rst_ops_done",  64'(ops_done),  64'd0);
        check("rst_rsp_data",  64'(rsp_data),  64'd0);

        // Write then read back the same address.
        doWrite(3'd3, 32'hDEAD_BEEF);
        doRead(3'd3);

        // Write, copy to a different register, read the destination.
        doWrite(3'd5, 32'h1234_5678);
        doCopy(3'd5, 3'd0);
        doRead(3'd0);

        // Top address and in-place copy.
        doWrite(3'd7, 32'hCAFE_F00D);
        doCopy(3'd7, 3'd7);
        doRead(3'd7);

        // Response back-pressure during a READ.
        rsp_ready = 1'b0;
        expRdQ.push_back(3'd3);
        sendCmd(2'b10, 3'd3, 3'd0, 32'h0, 1'b1, 32'hDEAD_BEEF, 2);
        begin
            int n = 0;
            while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
            check("stall_rsp_seen", 64'(rsp_valid), 64'd1);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_rsp_valid", 64'(rsp_valid), 64'd1);
            check("stall_rsp_data",  64'(rsp_data),  64'hDEAD_BEEF);
            check("stall_cmd_ready", 64'(cmd_ready), 64'd0);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        waitIdle();
        expOps++;
        check("ops_done_stall", 64'(ops_done), 64'(expOps));

        // Reset in the WR cycle of a WRITE: the write is suppressed and dropped.
        sendCmd(2'b01, 3'd6, 3'd0, 32'hA5A5_A5A5, 1'b0, 32'h0, 0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_wr_rf_we", 64'(rf_we), 64'd0);
        @(posedge clk); #1 reset = 1'b0;
        expOps = '0;
        check("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_mid_ops_done",  64'(ops_done),  64'd0);
        check("rst_mid_wAddr",     64'(rf_wAddr),  64'd0);
        check("rst_mid_wData",     64'(rf_wData),  64'd0);
        check("rst_mid_cmd_ready", 64'(cmd_ready), 64'd1);
        repeat (3) begin
            @(negedge clk);
            check("rst_mid_no_rsp", 64'(rsp_valid), 64'd0);
        end
        doRead(3'd6);

        // NOP is accepted and produces no response.
        sendCmd(2'b00, 3'd2, 3'd0, 32'h0, 1'b0, 32'h0, 0);
        repeat (4) begin
            @(negedge clk);
            check("nop_no_rsp", 64'(rsp_valid), 64'd0);
        end
        check("nop_ops_done", 64'(ops_done), 64'd1);

        // Counter wrap: 2^CW handshakes since reset bring ops_done back to 0.
        for (int i = 0; i < (1 << CW) - 2; i++) doRead(AW'(i % 8));
        check("ops_before_wrap", 64'(ops_done), 64'd255);
        doRead(3'd6);
        check("ops_wrap", 64'(ops_done), 64'd0);

        repeat (3) @(posedge clk);
        check("q_wr_empty",  64'(expWrQ.size()),  64'd0);
        check("q_rd_empty",  64'(expRdQ.size()),  64'd0);
        check("q_rsp_empty", 64'(expRspQ.size()), 64'd0);
        check("q_lat_empty", 64'(expLatQ.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule : tb_regfile_initiator
